// File: rtl/me_pkg.sv
// Shared types and helpers for the full-search motion-estimation scheduler.
package me_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } me_state_t;

   localparam int ME_MV_WIDTH = 5;

   typedef logic signed [ME_MV_WIDTH-1:0] me_offset_t;

   function automatic int num_cand(input int r);
      return (2 * r + 1) * (2 * r + 1);
   endfunction

endpackage

// File: rtl/me_offset_gen.sv
// Raster-order (dx,dy) generator over a +/-R window: dx sweeps -R..R, then wraps with dy+1.
module me_offset_gen #(
   parameter int MV_WIDTH = 5,
   parameter int R        = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_init,
   input  logic                       i_advance,
   output logic signed [MV_WIDTH-1:0] o_dx,
   output logic signed [MV_WIDTH-1:0] o_dy,
   output logic                       o_last
);

   localparam logic signed [MV_WIDTH-1:0] LP_POS = MV_WIDTH'(R);
   localparam logic signed [MV_WIDTH-1:0] LP_NEG = MV_WIDTH'(-R);

   logic signed [MV_WIDTH-1:0] r_dx;
   logic signed [MV_WIDTH-1:0] r_dy;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dx <= '0;
         r_dy <= '0;
      end else if (i_init) begin
         r_dx <= LP_NEG;
         r_dy <= LP_NEG;
      end else if (i_advance) begin
         if (r_dx == LP_POS) begin
            r_dx <= LP_NEG;
            r_dy <= r_dy + MV_WIDTH'(1);
         end else begin
            r_dx <= r_dx + MV_WIDTH'(1);
         end
      end
   end

   assign o_dx   = r_dx;
   assign o_dy   = r_dy;
   assign o_last = (r_dx == LP_POS) && (r_dy == LP_POS);

endmodule

// File: rtl/me_search_scheduler.sv
// Issues every candidate offset of a full-search window and tracks the minimum SAD
// together with its motion vector; pulses out_done once per pass.
module me_search_scheduler
   import me_pkg::*;
#(
   parameter int SAD_WIDTH    = 16,
   parameter int SEARCH_RANGE = 4,
   parameter int MV_WIDTH     = 5,
   parameter int CNT_WIDTH    = 9
) (
   input  logic                        in_clk,
   input  logic                        in_rst_n,
   input  logic                        in_start,
   output logic                        out_busy,
   output logic                        out_cand_valid,
   input  logic                        in_cand_ready,
   output logic signed [MV_WIDTH-1:0]  out_cand_dx,
   output logic signed [MV_WIDTH-1:0]  out_cand_dy,
   input  logic [SAD_WIDTH-1:0]        in_SAD,
   input  logic                        in_SAD_valid,
   output logic                        out_done,
   output logic [SAD_WIDTH-1:0]        out_best_SAD,
   output logic signed [MV_WIDTH-1:0]  out_best_dx,
   output logic signed [MV_WIDTH-1:0]  out_best_dy
);

   localparam int                         LP_N     = num_cand(SEARCH_RANGE);
   localparam logic [CNT_WIDTH-1:0]       LP_N_C   = CNT_WIDTH'(LP_N);
   localparam logic signed [MV_WIDTH-1:0] LP_NEG   = MV_WIDTH'(-SEARCH_RANGE);

   me_state_t r_state;
   me_state_t w_next_state;

   logic [SAD_WIDTH-1:0]       r_best_sad;
   logic signed [MV_WIDTH-1:0] r_best_dx;
   logic signed [MV_WIDTH-1:0] r_best_dy;
   logic [CNT_WIDTH-1:0]       r_res_cnt;

   logic                       w_idle;
   logic                       w_iss_fire;
   logic                       w_iss_last;
   logic signed [MV_WIDTH-1:0] w_iss_dx;
   logic signed [MV_WIDTH-1:0] w_iss_dy;
   logic                       w_res_accept;
   logic                       w_res_last;
   logic                       w_res_done;
   logic                       w_better;
   logic signed [MV_WIDTH-1:0] w_res_dx;
   logic signed [MV_WIDTH-1:0] w_res_dy;
   logic [SAD_WIDTH-1:0]       w_best_sad_nxt;
   logic signed [MV_WIDTH-1:0] w_best_dx_nxt;
   logic signed [MV_WIDTH-1:0] w_best_dy_nxt;

   assign w_idle       = (r_state == ST_IDLE);
   assign w_iss_fire   = (r_state == ST_ISSUE) && in_cand_ready;
   // Results beyond the candidate count are dropped so the minimum cannot be polluted.
   assign w_res_accept = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) &&
                         in_SAD_valid && (r_res_cnt != LP_N_C);
   assign w_better     = in_SAD < r_best_sad;
   assign w_res_done   = (r_res_cnt == LP_N_C) || (w_res_accept && w_res_last);

   me_offset_gen #(.MV_WIDTH(MV_WIDTH), .R(SEARCH_RANGE)) u_issue_gen (
      .i_clk     (in_clk),
      .i_rst_n   (in_rst_n),
      .i_init    (w_idle),
      .i_advance (w_iss_fire),
      .o_dx      (w_iss_dx),
      .o_dy      (w_iss_dy),
      .o_last    (w_iss_last)
   );

   me_offset_gen #(.MV_WIDTH(MV_WIDTH), .R(SEARCH_RANGE)) u_result_gen (
      .i_clk     (in_clk),
      .i_rst_n   (in_rst_n),
      .i_init    (w_idle),
      .i_advance (w_res_accept),
      .o_dx      (w_res_dx),
      .o_dy      (w_res_dy),
      .o_last    (w_res_last)
   );

   always_comb begin
      w_best_sad_nxt = r_best_sad;
      w_best_dx_nxt  = r_best_dx;
      w_best_dy_nxt  = r_best_dy;
      if (w_res_accept && w_better) begin
         w_best_sad_nxt = in_SAD;
         w_best_dx_nxt  = w_res_dx;
         w_best_dy_nxt  = w_res_dy;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (in_start) w_next_state = ST_ISSUE;
         ST_ISSUE: if (w_iss_fire && w_iss_last) w_next_state = ST_WAIT;
         ST_WAIT:  if (w_res_done) w_next_state = ST_DONE;
         ST_DONE:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Best defaults to (-R,-R) so a window of all-maximum SADs reports the first candidate.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_best_sad   <= '1;
         r_best_dx    <= '0;
         r_best_dy    <= '0;
         r_res_cnt    <= '0;
         out_best_SAD <= '0;
         out_best_dx  <= '0;
         out_best_dy  <= '0;
      end else if (w_idle) begin
         r_best_sad <= '1;
         r_best_dx  <= LP_NEG;
         r_best_dy  <= LP_NEG;
         r_res_cnt  <= '0;
      end else begin
         r_best_sad <= w_best_sad_nxt;
         r_best_dx  <= w_best_dx_nxt;
         r_best_dy  <= w_best_dy_nxt;
         if (w_res_accept) begin
            r_res_cnt <= r_res_cnt + CNT_WIDTH'(1);
         end
         if ((r_state == ST_WAIT) && w_res_done) begin
            out_best_SAD <= w_best_sad_nxt;
            out_best_dx  <= w_best_dx_nxt;
            out_best_dy  <= w_best_dy_nxt;
         end
      end
   end

   assign out_busy       = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
   assign out_cand_valid = (r_state == ST_ISSUE);
   assign out_cand_dx    = (r_state == ST_ISSUE) ? w_iss_dx : '0;
   assign out_cand_dy    = (r_state == ST_ISSUE) ? w_iss_dy : '0;
   assign out_done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_me_search_scheduler.sv
// Directed-plus-random bench: an R=1 and an R=4 scheduler share one SAD responder,
// and every pass is checked against a plain raster/minimum model of the window.
module tb_me_search_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start;
   logic        sel;
   int          lat;
   int          readyMode;
   logic [31:0] cyc = 32'd0;
   int          issCnt = 0;
   logic        r_sv = 1'b0;
   logic [15:0] r_sad = 16'd0;
   logic [15:0] sadTab [0:81];

   int compared;
   int mismatched;

   logic        busy1, cv1, done1, busy4, cv4, done4;
   logic signed [4:0] dx1, dy1, bdx1, bdy1, dx4, dy4, bdx4, bdy4;
   logic [15:0] bsad1, bsad4;

   logic        m_busy, m_cv, m_done, ready, sadV;
   logic signed [4:0] m_dx, m_dy, m_bdx, m_bdy;
   logic [15:0] m_bsad, sadVal;

   me_search_scheduler #(.SAD_WIDTH(16), .SEARCH_RANGE(1), .MV_WIDTH(5), .CNT_WIDTH(9)) dut1 (
      .in_clk(clk), .in_rst_n(rst_n), .in_start(start && !sel), .out_busy(busy1),
      .out_cand_valid(cv1), .in_cand_ready(ready), .out_cand_dx(dx1), .out_cand_dy(dy1),
      .in_SAD(sadVal), .in_SAD_valid(sadV && !sel), .out_done(done1),
      .out_best_SAD(bsad1), .out_best_dx(bdx1), .out_best_dy(bdy1)
   );

   me_search_scheduler #(.SAD_WIDTH(16), .SEARCH_RANGE(4), .MV_WIDTH(5), .CNT_WIDTH(9)) dut4 (
      .in_clk(clk), .in_rst_n(rst_n), .in_start(start && sel), .out_busy(busy4),
      .out_cand_valid(cv4), .in_cand_ready(ready), .out_cand_dx(dx4), .out_cand_dy(dy4),
      .in_SAD(sadVal), .in_SAD_valid(sadV && sel), .out_done(done4),
      .out_best_SAD(bsad4), .out_best_dx(bdx4), .out_best_dy(bdy4)
   );

   assign m_busy = sel ? busy4 : busy1;
   assign m_cv   = sel ? cv4   : cv1;
   assign m_done = sel ? done4 : done1;
   assign m_dx   = sel ? dx4   : dx1;
   assign m_dy   = sel ? dy4   : dy1;
   assign m_bsad = sel ? bsad4 : bsad1;
   assign m_bdx  = sel ? bdx4  : bdx1;
   assign m_bdy  = sel ? bdy4  : bdy1;

   // Ready pattern 1,0,0,1 repeating when backpressure is enabled.
   assign ready  = (readyMode == 0) || (cyc[1:0] == 2'd0) || (cyc[1:0] == 2'd3);
   assign sadV   = (lat == 0) ? (m_cv && ready) : r_sv;
   assign sadVal = (lat == 0) ? sadTab[issCnt] : r_sad;

   always @(posedge clk) begin
      cyc   <= cyc + 32'd1;
      r_sv  <= m_cv && ready && (lat == 1);
      r_sad <= sadTab[issCnt];
      if (!m_busy) issCnt <= 0;
      else if (m_cv && ready) issCnt <= issCnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: got %0d required %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   task automatic applyStimulus(input int r, input int rdyMode, input int latency,
                                input int abortAt, input bit pokeStart);
      int n, w, expIdx, doneCnt, bestIdx, tail;
      logic [15:0] bestSad;
      bit prevStall;
      logic signed [4:0] pdx, pdy;
      n = (2 * r + 1) * (2 * r + 1);
      w = 2 * r + 1;
      bestIdx = 0;
      bestSad = sadTab[0];
      for (int i = 1; i < n; i++) begin
         if (sadTab[i] < bestSad) begin
            bestSad = sadTab[i];
            bestIdx = i;
         end
      end
      sel = (r == 4);
      lat = latency;
      readyMode = rdyMode;
      expIdx = 0; doneCnt = 0; tail = 0; prevStall = 1'b0; pdx = '0; pdy = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 4000 && tail < 6; c++) begin
         if (abortAt > 0 && expIdx == abortAt) begin
            rst_n = 1'b0;
            start = 1'b0;
            #1;
            chk("abortBusy", 32'(m_busy), 32'd0);
            chk("abortValid", 32'(m_cv), 32'd0);
            chk("abortDone", 32'(m_done), 32'd0);
            chk("abortDx", 32'(m_dx), 32'd0);
            chk("abortBestSad", 32'(m_bsad), 32'd0);
            chk("abortBestDy", 32'(m_bdy), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (prevStall) begin
            chk("stallValid", 32'(m_cv), 32'd1);
            chk("stallDx", 32'(m_dx), 32'(pdx));
            chk("stallDy", 32'(m_dy), 32'(pdy));
         end
         if (m_cv && ready) begin
            chk("candDx", 32'(m_dx), 32'((expIdx % w) - r));
            chk("candDy", 32'(m_dy), 32'((expIdx / w) - r));
            expIdx++;
         end
         prevStall = m_cv && !ready;
         pdx = m_dx;
         pdy = m_dy;
         start = pokeStart && m_busy && (c == 3 || expIdx == n);
         if (m_done) begin
            doneCnt++;
            chk("busyAtDone", 32'(m_busy), 32'd0);
            chk("issuedCount", 32'(expIdx), 32'(n));
            chk("bestSad", 32'(m_bsad), 32'(bestSad));
            chk("bestDx", 32'(m_bdx), 32'((bestIdx % w) - r));
            chk("bestDy", 32'(m_bdy), 32'((bestIdx / w) - r));
         end
         if (doneCnt > 0) tail++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("doneCount", 32'(doneCnt), 32'd1);
      chk("bestHeld", 32'(m_bsad), 32'(bestSad));
   endtask

   task automatic fillRandom(input int n);
      for (int i = 0; i < n; i++) sadTab[i] = 16'($urandom_range(0, 2000));
   endtask

   initial begin
      logic [15:0] pat [0:8];
      compared = 0; mismatched = 0;
      rst_n = 1'b0; start = 1'b0; sel = 1'b0; lat = 1; readyMode = 0;
      for (int i = 0; i < 82; i++) sadTab[i] = 16'd0;
      #12;
      chk("rstBusy", 32'(m_busy), 32'd0);
      chk("rstValid", 32'(m_cv), 32'd0);
      chk("rstDone", 32'(m_done), 32'd0);
      chk("rstDx", 32'(m_dx), 32'd0);
      chk("rstBestSad", 32'(m_bsad), 32'd0);
      chk("rstBestDx", 32'(m_bdx), 32'd0);
      sel = 1'b1;
      #1;
      chk("rstBestSad4", 32'(m_bsad), 32'd0);
      chk("rstValid4", 32'(m_cv), 32'd0);
      sel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      pat = '{16'd90, 16'd80, 16'd70, 16'd60, 16'd5, 16'd60, 16'd70, 16'd80, 16'd90};
      for (int i = 0; i < 9; i++) sadTab[i] = pat[i];
      applyStimulus(1, 0, 1, 0, 1'b0);

      for (int i = 0; i < 9; i++) sadTab[i] = 16'd7;
      sadTab[2] = 16'd3;
      sadTab[6] = 16'd3;
      applyStimulus(1, 0, 1, 0, 1'b0);

      fillRandom(9);
      applyStimulus(1, 1, 1, 0, 1'b0);

      for (int i = 0; i < 81; i++) sadTab[i] = 16'hFFFF;
      applyStimulus(4, 0, 0, 0, 1'b0);

      fillRandom(81);
      applyStimulus(4, 0, 1, 0, 1'b1);

      fillRandom(81);
      applyStimulus(4, 1, 0, 0, 1'b1);

      fillRandom(81);
      applyStimulus(4, 0, 1, 40, 1'b0);
      repeat (2) @(negedge clk);
      fillRandom(81);
      applyStimulus(4, 0, 1, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/me_search_scheduler.md
Name: me_search_scheduler

Overview:
Sequences one full-search motion-estimation pass for a single current block. On in_start it issues every candidate offset (dx,dy) in the ±SEARCH_RANGE window to the SAD datapath over a valid/ready handshake. It consumes the in-order SAD results, tracks the minimum SAD together with its motion vector, and reports completion. It sits between the frame-level control and the SAD array, replacing count-based min tracking with vector-aware tracking.

Parameters:
SAD_WIDTH, 16, width of SAD values
SEARCH_RANGE, 4, window half-width R; candidates = (2R+1)^2 (81 at default)
MV_WIDTH, 5, signed two's-complement width of dx/dy; must hold ±R
CNT_WIDTH, 9, width of issue/result counters; must hold (2R+1)^2

Ports:
in_clk  input  1  clock, rising edge
in_rst_n  input  1  asynchronous active-low reset
in_start  input  1  start pulse, sampled in IDLE only
out_busy  output  1  high from the cycle after start acceptance until out_done
out_cand_valid  output  1  candidate offset valid
in_cand_ready  input  1  SAD datapath accepts candidate
out_cand_dx  output  MV_WIDTH  candidate horizontal offset, signed
out_cand_dy  output  MV_WIDTH  candidate vertical offset, signed
in_SAD  input  SAD_WIDTH  SAD result
in_SAD_valid  input  1  result valid, one per accepted candidate, in issue order
out_done  output  1  one-cycle completion pulse
out_best_SAD  output  SAD_WIDTH  minimum SAD of last pass
out_best_dx  output  MV_WIDTH  dx of minimum
out_best_dy  output  MV_WIDTH  dy of minimum

Behaviour:
- Reset, asynchronous, in_rst_n=0: state IDLE; out_busy=0, out_cand_valid=0, out_done=0, out_cand_dx/dy=0, out_best_SAD=0, out_best_dx/dy=0; internal best register all-ones; counters 0. Reset mid-pass aborts immediately. Late in_SAD_valid after reset release is ignored while in IDLE.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: in_start=1 -> ISSUE next cycle. Internal best register = all-ones, issue/result counters and both offset generators = (-R,-R).
- ISSUE: out_cand_valid=1 and out_cand_dx/dy = issue generator. Transfer occurs when valid&&ready. On transfer, the generator advances in raster order: dx increments -R..R, then wraps to -R with dy+1. dx/dy are held stable while ready=0. The transfer of the last candidate, (R,R), -> WAIT with out_cand_valid=0 next cycle.
- Result side, active in ISSUE and WAIT: each in_SAD_valid compares in_SAD with the best register. Strictly less -> update best SAD and best dx/dy from the result generator. Ties keep the earlier candidate. The result generator and counter then advance. A result may arrive in the same cycle as any issue transfer, including the last one; both are processed.
- WAIT -> DONE in the cycle the result counter reaches (2R+1)^2, including the final result itself. Extra results beyond the count are ignored.
- DONE, exactly one cycle: out_done=1, out_best_* <= internal best, out_busy drops to 0 in the same cycle, then -> IDLE. out_best_* hold until the next DONE.
- in_start is ignored outside IDLE.
- in_SAD_valid is ignored in IDLE and DONE.
- Minimum pass latency with ready tied high and a 1-cycle SAD pipe: N+3 cycles from start to done.

Decomposition:
- Shared package me_pkg: FSM state enum (2-bit); function num_cand(R) = (2R+1)^2; signed offset typedef of MV_WIDTH.
- One sub-module: me_offset_gen. It is a raster dx/dy generator with init, advance and last-flag. It is instantiated twice, once for the issue side and once for the result side.

Test Plan:
- R=1, ready=1, 1-cycle SAD pipe, SADs 90,80,70,60,5,60,70,80,90 -> 9 candidates issued in order (-1,-1)..(1,1); out_done pulses once; best SAD=5, dx=0, dy=0.
- Tie: R=1, all SADs=7 except index 2=3 and index 6=3 -> best SAD=3, (dx,dy)=(1,-1), the earliest tie.
- Backpressure: ready toggling 1,0,0,1 repeating -> offsets held stable during stalls; no candidate skipped or duplicated; 9 results counted; correct done.
- Last result coincides with last issue (combinational SAD return): the pass completes and the count is exact; default R=4 issues 81 candidates; max SAD 16'hFFFF on all -> best=FFFF at (-4,-4).
- Async reset asserted mid-ISSUE (after 40 transfers) -> outputs reset immediately; a new start runs a full clean 81-candidate pass.
- in_start pulsed during ISSUE and WAIT -> ignored; exactly one out_done per accepted start.
